// File: rtl/line_mem_pkg.sv
// Shared types and helpers for the line memory responder: FSM states,
// default geometry and the pattern generator for never-written lines.
package line_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    HIT     = 3'd2,
    DONE    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam int LINE_BYTES_DEF  = 64;
  localparam int DEPTH_LINES_DEF = 256;
  localparam int OFFSET_W        = $clog2(LINE_BYTES_DEF);
  localparam int INDEX_W         = $clog2(DEPTH_LINES_DEF);

  // Widest line the pattern helper can produce; callers truncate to their width.
  localparam int MAX_LINE_BYTES  = 256;

  // Word i of an unwritten line is the word-aligned line base plus 4*i.
  function automatic logic [8*MAX_LINE_BYTES-1:0] init_line(input logic [31:0] base_addr,
                                                            input logic        mode);
    logic [8*MAX_LINE_BYTES-1:0] line;
    line = '0;
    if (mode) begin
      for (int i = 0; i < MAX_LINE_BYTES / 4; i++) begin
        line[32*i +: 32] = (base_addr & 32'hFFFF_FFFC) + 32'(4 * i);
      end
    end
    return line;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Single-port line storage with per-line written bits; unwritten lines read
// back as the init pattern, and writes merge enabled bytes into that view.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int LINE_BYTES  = LINE_BYTES_DEF,
  parameter int DEPTH_LINES = DEPTH_LINES_DEF,
  parameter int ADDR_W      = 32,
  parameter int INIT_MODE   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(DEPTH_LINES)-1:0] index,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic                           we,
  input  logic [8*LINE_BYTES-1:0]        wdata,
  input  logic [LINE_BYTES-1:0]          wmask,
  output logic [8*LINE_BYTES-1:0]        rdata,
  output logic [8*LINE_BYTES-1:0]        merged
);

  logic [8*LINE_BYTES-1:0] mem [DEPTH_LINES];
  logic [DEPTH_LINES-1:0]  written;
  logic [8*LINE_BYTES-1:0] pattern;

  assign pattern = (8*LINE_BYTES)'(init_line(32'(base_addr), INIT_MODE != 0));
  assign rdata   = written[index] ? mem[index] : pattern;

  always_comb begin
    merged = rdata;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (wmask[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // A write landing on the same edge as reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      written <= '0;
    end else if (we) begin
      written[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && we) begin
      mem[index] <= merged;
    end
  end

endmodule

// File: rtl/line_mem_model.sv
// Fixed-latency line responder for the lower mem_if side: latches one request,
// waits LATENCY cycles, performs the array access, then reports completion.
//
// state   | meaning
// IDLE    | waiting for read_en/write_en
// WAIT    | latency countdown, LATENCY cycles
// HIT     | hit pulse; array read/write performed at the closing edge
// DONE    | done pulse; data_o valid
// RECOVER | one dead cycle so a held enable cannot re-trigger at once
module line_mem_model
  import line_mem_pkg::*;
#(
  parameter int LINE_BYTES  = LINE_BYTES_DEF,
  parameter int DEPTH_LINES = DEPTH_LINES_DEF,
  parameter int LATENCY     = 10,
  parameter int ADDR_W      = 32,
  parameter int INIT_MODE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    read_en,
  input  logic                    write_en,
  input  logic [8*LINE_BYTES-1:0] data_i,
  input  logic [LINE_BYTES-1:0]   data_en,
  output logic [8*LINE_BYTES-1:0] data_o,
  output logic                    hit,
  output logic                    done,
  output logic                    busy,
  output logic [31:0]             req_count
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_W-1:0]       lat_addr;
  logic                    lat_write;
  logic [8*LINE_BYTES-1:0] lat_data;
  logic [LINE_BYTES-1:0]   lat_en;
  logic [ADDR_W-1:0]       line_base;
  logic [8*LINE_BYTES-1:0] rdata;
  logic [8*LINE_BYTES-1:0] merged;
  logic                    array_we;

  assign line_base = lat_addr & ~ADDR_W'(LINE_BYTES - 1);
  assign array_we  = (state == HIT) && lat_write;

  line_mem_array #(
    .LINE_BYTES  (LINE_BYTES),
    .DEPTH_LINES (DEPTH_LINES),
    .ADDR_W      (ADDR_W),
    .INIT_MODE   (INIT_MODE)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .index     (lat_addr[OFF_W +: IDX_W]),
    .base_addr (line_base),
    .we        (array_we),
    .wdata     (lat_data),
    .wmask     (lat_en),
    .rdata     (rdata),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (read_en || write_en) state_nxt = WAIT;
      end
      WAIT:    if (cnt == '0) state_nxt = HIT;
      HIT: begin
        hit       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = RECOVER;
      end
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_data  <= '0;
      lat_en    <= '0;
      data_o    <= '0;
      req_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_en || write_en) begin
            cnt       <= CNT_W'(LATENCY - 1);
            lat_addr  <= addr;
            lat_write <= write_en;
            lat_data  <= data_i;
            lat_en    <= data_en;
          end
        end
        WAIT:    if (cnt != '0) cnt <= cnt - CNT_W'(1);
        HIT:     data_o <= lat_write ? merged : rdata;
        DONE:    req_count <= req_count + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_model.sv
// Scoreboard bench for line_mem_model: a line-array reference model predicts
// each response; a negedge monitor checks hit/done/busy timing and data.
module tb_line_mem_model;

  localparam int LB  = 64;
  localparam int DL  = 16;
  localparam int LAT = 10;
  localparam int AW  = 32;
  localparam int LW  = 8 * LB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          read_en = 1'b0;
  logic          write_en = 1'b0;
  logic [LW-1:0] data_i = '0;
  logic [LB-1:0] data_en = '0;
  logic [LW-1:0] data_o;
  logic          hit, done, busy;
  logic [31:0]   req_count;

  always #5 clk = ~clk;

  line_mem_model #(
    .LINE_BYTES(LB), .DEPTH_LINES(DL), .LATENCY(LAT), .ADDR_W(AW), .INIT_MODE(1)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .read_en(read_en), .write_en(write_en),
    .data_i(data_i), .data_en(data_en), .data_o(data_o), .hit(hit), .done(done),
    .busy(busy), .req_count(req_count)
  );

  typedef struct {
    int            hit_cyc;
    int            done_cyc;
    logic [LW-1:0] data;
    int            cnt;
  } exp_t;

  exp_t          sb[$];
  logic [LW-1:0] m_line [DL];
  bit            m_wr [DL];
  int cyc = 0;
  int errors = 0, checks = 0;
  int exp_cnt = 0, next_free = 0;
  int busy_from = -1, busy_until = -2;
  int cnt_check_cyc = -1, cnt_check_val = 0;
  int done_seen = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] pattern(input logic [31:0] a);
    logic [LW-1:0] l;
    logic [31:0]   base;
    base = a - (a % LB);
    for (int i = 0; i < LB / 4; i++) l[32*i +: 32] = base + 32'(4 * i);
    return l;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / LB) % DL);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LB / 4; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Request sampled at the end of the current cycle c: hit at c+LAT+1, done at c+LAT+2.
  task automatic accept_now(input logic [31:0] a, input bit we,
                            input logic [LW-1:0] d, input logic [LB-1:0] en);
    exp_t          e;
    int            k;
    logic [LW-1:0] cur;
    k   = idx_of(a);
    cur = m_wr[k] ? m_line[k] : pattern(a);
    if (we) begin
      for (int b = 0; b < LB; b++) if (en[b]) cur[8*b +: 8] = d[8*b +: 8];
      m_line[k] = cur;
      m_wr[k]   = 1'b1;
    end
    exp_cnt++;
    e.hit_cyc  = cyc + LAT + 1;
    e.done_cyc = cyc + LAT + 2;
    e.data     = cur;
    e.cnt      = exp_cnt;
    sb.push_back(e);
    busy_from  = cyc + 1;
    busy_until = cyc + LAT + 3;
    next_free  = cyc + LAT + 4;
  endtask

  task automatic do_req(input logic [31:0] a, input bit re, input bit we,
                        input logic [LW-1:0] d, input logic [LB-1:0] en, input int gap);
    while (cyc < next_free) @(negedge clk);
    repeat (gap) @(negedge clk);
    addr = a; read_en = re; write_en = we; data_i = d; data_en = en;
    accept_now(a, we, d, en);
    @(negedge clk);
    read_en = 1'b0; write_en = 1'b0;
    addr = $urandom; data_i = rand_line(); data_en = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses pending, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    bit eh, ed, eb;
    if (mon_en) begin
      eh = sb.size() > 0 && sb[0].hit_cyc == cyc;
      ed = sb.size() > 0 && sb[0].done_cyc == cyc;
      eb = cyc >= busy_from && cyc <= busy_until;
      if (hit || eh)  chk("hit_pulse", LW'(hit), LW'(eh));
      if (done || ed) chk("done_pulse", LW'(done), LW'(ed));
      chk("busy", LW'(busy), LW'(eb));
      if (done) done_seen++;
      if (cyc == cnt_check_cyc) chk("req_count", LW'(req_count), LW'(cnt_check_val));
      if (ed) begin
        if (done) chk("data_o", data_o, sb[0].data);
        cnt_check_cyc = cyc + 1;
        cnt_check_val = sb[0].cnt;
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [LB-1:0] en;
    int op;
    foreach (m_wr[i]) m_wr[i] = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    chk("reset_data_o", data_o, '0);
    chk("reset_req_count", LW'(req_count), '0);
    next_free = cyc;

    // Cold read of an untouched line
    do_req(32'hAABB0040, 1, 0, rand_line(), '1, 0);
    drain();
    chk("cold_word0", LW'(data_o[31:0]), LW'(32'hAABB0040));
    chk("cold_word15", LW'(data_o[511:480]), LW'(32'hAABB007C));
    chk("cold_count", LW'(req_count), LW'(1));

    // Masked writes keep the pattern in unmasked bytes
    do_req(32'h00001000, 0, 1, {64{8'h11}}, 64'h000F, 1);
    drain();
    chk("mw1_word0", LW'(data_o[31:0]), LW'(32'h11111111));
    chk("mw1_word1", LW'(data_o[63:32]), LW'(32'h00001004));
    do_req(32'h00001000, 1, 0, '0, '0, 0);
    drain();
    chk("mw1_rd_word0", LW'(data_o[31:0]), LW'(32'h11111111));
    chk("mw1_rd_word1", LW'(data_o[63:32]), LW'(32'h00001004));
    do_req(32'h00001000, 0, 1, {64{8'h22}}, 64'h00F0, 2);
    drain();
    chk("mw2_word0", LW'(data_o[31:0]), LW'(32'h11111111));
    chk("mw2_word1", LW'(data_o[63:32]), LW'(32'h22222222));

    // Index aliasing with 16 lines of 64 bytes
    do_req(32'h00000000, 0, 1, LW'(32'hDEADBEEF), 64'h000F, 0);
    do_req(32'h00000400, 1, 0, '0, '0, 0);
    drain();
    chk("alias_word0", LW'(data_o[31:0]), LW'(32'hDEADBEEF));

    // Read and write together behave as a write
    do_req(32'h00000080, 1, 1, {64{8'h5A}}, '1, 0);
    drain();
    chk("both_en_data", data_o, {64{8'h5A}});
    do_req(32'h00000080, 1, 0, '0, '0, 1);
    drain();
    chk("both_en_readback", data_o, {64{8'h5A}});

    // Held read enable: one acceptance every LAT+4 cycles
    while (cyc < next_free) @(negedge clk);
    d0 = done_seen;
    addr = 32'h000000C0; read_en = 1'b1; write_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (cyc >= next_free) accept_now(addr, 1'b0, data_i, data_en);
      @(negedge clk);
    end
    read_en = 1'b0;
    drain();
    chk("held_done_count", LW'(done_seen - d0), LW'(3));

    // Reset during WAIT of a write drops it and clears every line
    do_req(32'h00000140, 0, 1, {64{8'hC3}}, '1, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    foreach (m_wr[i]) m_wr[i] = 1'b0;
    exp_cnt = 0;
    busy_until = cyc;
    cnt_check_cyc = -1;
    @(negedge clk);
    reset = 1'b1;
    next_free = cyc;
    chk("rst_mid_count", LW'(req_count), '0);
    chk("rst_mid_data_o", data_o, '0);
    repeat (15) @(negedge clk);
    do_req(32'h00000140, 1, 0, '0, '0, 0);
    drain();
    chk("rst_mid_readback", data_o, pattern(32'h00000140));
    chk("rst_alias_cleared", LW'(m_wr[0]), '0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       en = '0;
        1:       en = '1;
        default: en = {$urandom, $urandom};
      endcase
      do_req($urandom, op != 2, op >= 2, rand_line(), en, $urandom_range(0, 3));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_mem_model.md
Name: line_mem_model

Overview:
- Synthesizable, parametrised lower-memory responder. It sits below cache_coupler on the `lower` mem_if side and replaces the behavioural line-service loop used in cache benches.
- Services line-wide reads and byte-masked writes with a programmable fixed latency, using real backing storage.
- Lines that have never been written read back as a deterministic address pattern, so benches can self-check without preloading memory.

Parameters:
- LINE_BYTES, 64, bytes per line; power of two, ≥4.
- DEPTH_LINES, 256, backing lines; power of two. Index = addr[$clog2(LINE_BYTES) +: $clog2(DEPTH_LINES)].
- LATENCY, 10, cycles spent in WAIT; ≥1.
- ADDR_W, 32, address width.
- INIT_MODE, 1, selects unwritten-line contents. 1 = address pattern; 0 = all zeros.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- addr  in  ADDR_W  request address; low $clog2(LINE_BYTES) bits ignored.
- read_en  in  1  read request.
- write_en  in  1  write request.
- data_i  in  8*LINE_BYTES  write data.
- data_en  in  LINE_BYTES  byte enables for writes.
- data_o  out  8*LINE_BYTES  read data (writes return the merged line).
- hit  out  1  one-cycle pulse, one cycle before done.
- done  out  1  one-cycle pulse; data_o valid in this cycle.
- busy  out  1  high in any state other than IDLE.
- req_count  out  32  count of completed requests; wraps.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; hit=done=busy=0; data_o=0; req_count=0.
  - All per-line written bits cleared, so every line reverts to its INIT contents.
  - Applies mid-request: any pending operation is dropped and its write is not performed.
- Unwritten line contents: word i = {line_base[ADDR_W-1:2], 2'b00} + 4*i, where line_base = addr with offset bits zeroed. INIT_MODE=0 gives zeros instead.
- FSM: IDLE → WAIT → HIT → DONE → RECOVER → IDLE.
  - IDLE: if read_en|write_en is sampled at posedge T, latch addr, op, data_i, data_en; go to WAIT with counter = LATENCY-1.
  - WAIT: decrement each cycle; go to HIT on the cycle after counter==0. WAIT lasts exactly LATENCY cycles.
  - HIT: hit=1. The array operation is performed at this edge.
    - Write merge: each byte b with data_en[b]=1 takes data_i; others keep current contents (pattern if unwritten). The line's written bit is set.
  - DONE: done=1; data_o = read line, or merged line for a write; req_count++.
  - RECOVER: one cycle; enables ignored. This stops a requester still holding its enable from re-triggering.
- Timing: hit is high in cycle T+LATENCY+1; done in cycle T+LATENCY+2. Next acceptance is possible no earlier than T+LATENCY+4.
- read_en and write_en both high: treated as a write.
- Request inputs are ignored outside IDLE. Changes to addr/data during WAIT have no effect.
- data_o holds its value after done until the next DONE or reset. hit and done are never high together.
- Address bits above the index alias (modulo DEPTH_LINES).
- data_en=0 on a write: no bytes change, but the line is still marked written. Its data is the frozen pattern, so values are identical.

Decomposition:
- Package line_mem_pkg:
  - state enum {IDLE, WAIT, HIT, DONE, RECOVER}.
  - Function init_line(base_addr, mode) returning the pattern line.
  - Localparams OFFSET_W and INDEX_W.
- Sub-module line_mem_array: DEPTH_LINES × 8*LINE_BYTES storage plus written bits. Single port, byte-masked write, combinational read, written-bit clear on reset.

Test Plan:
- Cold read: LATENCY=10, read addr 0xAABB0040 accepted at T. Expect hit at T+11, done at T+12, data_o word0=0xAABB0040, word15=0xAABB007C, req_count=1.
- Masked write then read:
  - Write to 0x00001000 with data_i all 0x11 and data_en=0x000F.
  - Readback: bytes 0-3 = 0x11; word1 = 0x00001004 (pattern preserved).
  - A second write with data_en=0x00F0 and 0x22 leaves bytes 0-3 = 0x11.
- Held enable: keep read_en=1 continuously for 40 cycles. Expect exactly one done per 14-cycle period (LATENCY+4) and no back-to-back done pulses.
- Aliasing: DEPTH_LINES=16, LINE_BYTES=64. Write 0xDEADBEEF to word0 of 0x0000_0000. Reading 0x0000_0400 returns word0=0xDEADBEEF.
- Reset mid-request: assert reset during WAIT of a write. Expect busy=0, done never pulses, req_count=0; a subsequent read returns the pattern.
- Simultaneous read_en=write_en=1 to 0x80 with data_en all ones and data 0x5A. Expect data_o all 0x5A, and a following read returns 0x5A.
